// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader driving the instruction memory write port.
// Keeps the core in reset until a whole frame has been written and its XOR checksum matches.
module imem_loader #(
   parameter int unsigned ADDR_W  = 6,
   parameter int unsigned DEPTH   = 64,
   parameter logic [7:0]  SYNC    = 8'hA5,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
   localparam int unsigned N_W  = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CHECK, S_DONE, S_ERROR
   } state_t;

   state_t            state_q, state_d;
   logic [N_W-1:0]    left_q, left_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        hi_q, hi_d;
   logic [7:0]        sum_q, sum_d;
   logic [TO_W-1:0]   idle_q, idle_d;
   logic              in_ready_q, in_ready_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [15:0]       wr_data_q, wr_data_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              accept;

   always_comb begin
      state_d   = state_q;
      left_d    = left_q;
      addr_d    = addr_q;
      hi_d      = hi_q;
      sum_d     = sum_q;
      idle_d    = '0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      accept    = in_valid & in_ready_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (accept && in_data == SYNC) state_d = S_COUNT;
         end
         S_COUNT: begin
            if (accept) begin
               addr_d = '0;
               sum_d  = in_data;
               if (32'(in_data) > DEPTH) begin
                  state_d = S_ERROR;
               end else begin
                  state_d = S_HI;
                  left_d  = (in_data == 8'd0) ? N_W'(DEPTH) : N_W'(in_data);
               end
            end
         end
         S_HI: begin
            if (accept) begin
               hi_d    = in_data;
               sum_d   = sum_q ^ in_data;
               state_d = S_LO;
            end
         end
         S_LO: begin
            if (accept) begin
               sum_d     = sum_q ^ in_data;
               wr_addr_d = addr_q;
               wr_data_d = {hi_q, in_data};
               state_d   = S_WRITE;
            end
         end
         S_WRITE: begin
            addr_d  = addr_q + 1'b1;
            left_d  = left_q - 1'b1;
            state_d = (left_q == N_W'(1)) ? S_CHECK : S_HI;
         end
         S_CHECK: begin
            if (accept) state_d = (in_data == sum_q) ? S_DONE : S_ERROR;
         end
         default: state_d = S_IDLE;
      endcase

      // Stall watchdog: only runs while a frame is waiting on the byte source.
      if (state_q inside {S_COUNT, S_HI, S_LO, S_CHECK} && !accept) begin
         if (idle_q == TO_W'(TIMEOUT - 1)) begin
            state_d = S_ERROR;
         end else begin
            idle_d = idle_q + 1'b1;
         end
      end

      in_ready_d = (state_d != S_WRITE);
      wr_en_d    = (state_d == S_WRITE);
      cpu_hold_d = (state_d != S_DONE);
      done_d     = (state_d == S_DONE);
      err_d      = (state_d == S_ERROR);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         left_q     <= '0;
         addr_q     <= '0;
         hi_q       <= '0;
         sum_q      <= '0;
         idle_q     <= '0;
         in_ready_q <= 1'b1;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         left_q     <= left_d;
         addr_q     <= addr_d;
         hi_q       <= hi_d;
         sum_q      <= sum_d;
         idle_q     <= idle_d;
         in_ready_q <= in_ready_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign in_ready = in_ready_q;
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign cpu_hold = cpu_hold_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: cycle-exact vector table plus randomized framed streams
// scored against a byte-level frame parser.
module tb_imem_loader;
   localparam int unsigned ADDR_W  = 6;
   localparam int unsigned DEPTH   = 64;
   localparam logic [7:0]  SYNC    = 8'hA5;
   localparam int unsigned TIMEOUT = 1023;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic              cpu_hold;
   logic              done;
   logic              err;

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rn;
      logic        v;
      logic [7:0]  d;
      logic        r;
      logic        w;
      logic [5:0]  a;
      logic [15:0] wd;
      logic        dn;
      logic        e;
      logic        h;
   } vec_t;

   typedef logic [7:0] byte_q_t[$];

   vec_t        tbl[$];
   logic [5:0]  la = '0;
   logic [15:0] ld = '0;

   function void add(input logic rn, input logic v, input logic [7:0] d, input logic r,
                     input logic w, input logic dn, input logic e, input logic h);
      vec_t x;
      x.rn = rn; x.v = v; x.d = d; x.r = r; x.w = w; x.a = la; x.wd = ld;
      x.dn = dn; x.e = e; x.h = h;
      tbl.push_back(x);
   endfunction

   function void add_reset();
      la = '0; ld = '0;
      add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
   endfunction

   // A5 02 12 34 AB CD 42, offered every cycle; bytes offered during WRITE are held.
   function void add_good();
      add(1, 1, 8'hA5, 1, 0, 0, 0, 1);
      add(1, 1, 8'h02, 1, 0, 0, 0, 1);
      add(1, 1, 8'h12, 1, 0, 0, 0, 1);
      la = 6'd0; ld = 16'h1234;
      add(1, 1, 8'h34, 0, 1, 0, 0, 1);
      add(1, 1, 8'hAB, 1, 0, 0, 0, 1);
      add(1, 1, 8'hAB, 1, 0, 0, 0, 1);
      la = 6'd1; ld = 16'hABCD;
      add(1, 1, 8'hCD, 0, 1, 0, 0, 1);
      add(1, 1, 8'h42, 1, 0, 0, 0, 1);
      add(1, 1, 8'h42, 1, 0, 1, 0, 0);
      add(1, 0, 8'h00, 1, 0, 1, 0, 0);
   endfunction

   // Scoreboard of observed writes and the handshake/strobe exclusivity.
   logic [21:0] got_q[$];
   int          ready_viol = 0;
   always @(negedge clk) begin
      if (rst) begin
         if (wr_en) got_q.push_back({wr_addr, wr_data});
         if (in_ready == wr_en) ready_viol++;
      end
   end

   // Reference: parse the accepted byte sequence frame by frame.
   logic [21:0] exp_q[$];
   int          mstat;  // 0 no result, 1 done, 2 err

   function void model(input byte_q_t s);
      int i;
      int words;
      logic [7:0] x;
      logic [7:0] hi;
      logic [7:0] lo;
      exp_q.delete();
      mstat = 0;
      i = 0;
      while (i < s.size()) begin
         if (s[i] != SYNC || i + 1 >= s.size()) begin
            i++;
         end else if (int'(s[i+1]) > int'(DEPTH)) begin
            mstat = 2;
            i += 2;
         end else begin
            words = (s[i+1] == 8'd0) ? int'(DEPTH) : int'(s[i+1]);
            x = s[i+1];
            for (int w = 0; w < words; w++) begin
               hi = s[i+2+2*w];
               lo = s[i+3+2*w];
               x = x ^ hi ^ lo;
               exp_q.push_back({6'(w), hi, lo});
            end
            mstat = (s[i+2+2*words] == x) ? 1 : 2;
            i += 3 + 2 * words;
         end
      end
   endfunction

   task automatic send_byte(input logic [7:0] b);
      int  gap;
      bit  acc;
      bit  ok;
      gap = int'($urandom_range(0, 2));
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) ok = 1'b1;
      end
      in_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL handshake: byte %h not accepted within 50 cycles, required acceptance", b);
      end
   endtask

   task automatic run_stream(input byte_q_t s, input string name);
      int n;
      got_q.delete();
      model(s);
      foreach (s[i]) send_byte(s[i]);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s write count: got %0d required %0d", name, got_q.size(), exp_q.size());
      end
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s write %0d: got addr=%0d data=%h required addr=%0d data=%h",
                     name, i, got_q[i][21:16], got_q[i][15:0], exp_q[i][21:16], exp_q[i][15:0]);
         end
      end
      checks++;
      if ({done, err, cpu_hold} !== {mstat == 1, mstat == 2, mstat != 1}) begin
         errors++;
         $display("FAIL %s status: got done=%b err=%b hold=%b required done=%b err=%b hold=%b",
                  name, done, err, cpu_hold, mstat == 1, mstat == 2, mstat != 1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      byte_q_t     s;
      logic [7:0]  x;
      logic [7:0]  b;
      int          nf;
      int          n;

      add_reset();
      add_good();
      // bad checksum A5 01 00 07 00
      add(1, 1, 8'hA5, 1, 0, 0, 0, 1);
      add(1, 1, 8'h01, 1, 0, 0, 0, 1);
      add(1, 1, 8'h00, 1, 0, 0, 0, 1);
      la = 6'd0; ld = 16'h0007;
      add(1, 1, 8'h07, 0, 1, 0, 0, 1);
      add(1, 1, 8'h00, 1, 0, 0, 0, 1);
      add(1, 1, 8'h00, 1, 0, 0, 1, 1);
      add_good();
      // oversize count
      add(1, 1, 8'hA5, 1, 0, 0, 0, 1);
      add(1, 1, 8'h41, 1, 0, 0, 1, 1);
      add(1, 0, 8'h00, 1, 0, 0, 1, 1);
      // noise from reset, then the good frame
      add_reset();
      add(1, 1, 8'h00, 1, 0, 0, 0, 1);
      add(1, 1, 8'hFF, 1, 0, 0, 0, 1);
      add(1, 1, 8'h5A, 1, 0, 0, 0, 1);
      add_good();
      // reset mid-frame after A5 01
      add(1, 1, 8'hA5, 1, 0, 0, 0, 1);
      add(1, 1, 8'h01, 1, 0, 0, 0, 1);
      add_reset();
      add(1, 0, 8'h00, 1, 0, 0, 0, 1);
      add(1, 1, 8'h12, 1, 0, 0, 0, 1);
      add(1, 1, 8'h34, 1, 0, 0, 0, 1);

      @(posedge clk); #1;
      foreach (tbl[i]) begin
         rst      = tbl[i].rn;
         in_valid = tbl[i].v;
         in_data  = tbl[i].d;
         @(posedge clk); #1;
         checks++;
         if ({in_ready, wr_en, wr_addr, wr_data, done, err, cpu_hold} !==
             {tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].dn, tbl[i].e, tbl[i].h}) begin
            errors++;
            $display("FAIL vec%0d: got rdy=%b wr=%b addr=%0d data=%h done=%b err=%b hold=%b required rdy=%b wr=%b addr=%0d data=%h done=%b err=%b hold=%b",
                     i, in_ready, wr_en, wr_addr, wr_data, done, err, cpu_hold,
                     tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].dn, tbl[i].e, tbl[i].h);
         end
      end
      rst = 1'b1;
      in_valid = 1'b0;

      // full-depth frame: count 00, 128 data bytes
      s.delete();
      s.push_back(SYNC);
      s.push_back(8'h00);
      x = 8'h00;
      for (int j = 0; j < 2 * int'(DEPTH); j++) begin
         b = 8'(j * 7 + 3);
         s.push_back(b);
         x ^= b;
      end
      s.push_back(x);
      run_stream(s, "full_depth");

      // randomized multi-frame streams
      for (int t = 0; t < 8; t++) begin
         s.delete();
         nf = int'($urandom_range(1, 3));
         for (int f = 0; f < nf; f++) begin
            n = int'($urandom_range(0, 2));
            for (int k = 0; k < n; k++) begin
               b = 8'($urandom_range(0, 255));
               if (b == SYNC) b = 8'h00;
               s.push_back(b);
            end
            s.push_back(SYNC);
            if ($urandom_range(0, 7) == 0) begin
               s.push_back(8'($urandom_range(65, 255)));
            end else begin
               n = int'($urandom_range(1, 6));
               s.push_back(8'(n));
               x = 8'(n);
               for (int k = 0; k < 2 * n; k++) begin
                  b = 8'($urandom_range(0, 255));
                  s.push_back(b);
                  x ^= b;
               end
               if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
               s.push_back(x);
            end
         end
         run_stream(s, $sformatf("rand%0d", t));
      end

      // timeout: A5 01 12 then stall
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      got_q.delete();
      send_byte(SYNC);
      send_byte(8'h01);
      send_byte(8'h12);
      repeat (TIMEOUT - 1) @(posedge clk);
      #1;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: got err=%b required err=0", err);
      end
      @(posedge clk); #1;
      checks++;
      if ({err, cpu_hold, done} !== 3'b110) begin
         errors++;
         $display("FAIL timeout_err: got err=%b hold=%b done=%b required err=1 hold=1 done=0",
                  err, cpu_hold, done);
      end
      checks++;
      if (got_q.size() != 0) begin
         errors++;
         $display("FAIL timeout_writes: got %0d writes required 0", got_q.size());
      end

      checks++;
      if (ready_viol != 0) begin
         errors++;
         $display("FAIL ready_vs_wr_en: got %0d cycles with in_ready==wr_en required 0", ready_viol);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
